// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator status, digit codes and segment patterns
package calc_pkg;

    typedef enum logic [1:0] {
        ERRO    = 2'b00,
        PRONTA  = 2'b01,
        OCUPADA = 2'b10,
        IMPRIME = 2'b11
    } calc_status_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_COMMIT  = 2'd2
    } cap_state_t;

    localparam logic [3:0] DIG_MINUS = 4'hA;
    localparam logic [3:0] DIG_BLANK = 4'hF;

    // Active-low, bit7 = dp (always off), bits6..0 = g..a
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_R     = 8'hAF;
    localparam logic [7:0] SEG_O     = 8'hA3;

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - digit code / error glyph to active-low segment pattern
module seg7_decoder
    import calc_pkg::*;
(
    input  logic [3:0] code,
    input  logic       err,
    output logic [7:0] seg
);

    // In error mode the code is the scan position: 3..0 spell "Erro", higher positions blank
    always_comb begin
        seg = SEG_BLANK;
        if (err) begin
            case (code)
                4'd0:       seg = SEG_O;
                4'd1, 4'd2: seg = SEG_R;
                4'd3:       seg = SEG_E;
                default:    seg = SEG_BLANK;
            endcase
        end else begin
            case (code)
                4'd0:      seg = SEG_0;
                4'd1:      seg = SEG_1;
                4'd2:      seg = SEG_2;
                4'd3:      seg = SEG_3;
                4'd4:      seg = SEG_4;
                4'd5:      seg = SEG_5;
                4'd6:      seg = SEG_6;
                4'd7:      seg = SEG_7;
                4'd8:      seg = SEG_8;
                4'd9:      seg = SEG_9;
                DIG_MINUS: seg = SEG_MINUS;
                default:   seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/calc_display.sv
// rtl/calc_display.sv - frame capture into a shadow buffer and multiplexed 8-digit scan
module calc_display
    import calc_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] status,
    input  logic [3:0] pos,
    input  logic [3:0] dig,
    output logic [7:0] an,
    output logic [7:0] seg,
    output logic       frame_ok,
    output logic       pos_ovf
);

    cap_state_t   state, state_nxt;
    calc_status_t st;
    logic         cap_clr, cap_wr, pos_ok;
    logic [3:0]   shadow [8];
    logic [3:0]   disp   [8];
    logic [15:0]  scan_cnt;
    logic [2:0]   scan_idx;
    logic         err_mode;
    logic [3:0]   dec_code;
    logic [7:0]   dec_seg;

    assign st     = calc_status_t'(status);
    assign pos_ok = ~pos[3];

    always_comb begin
        state_nxt = state;
        cap_clr   = 1'b0;
        cap_wr    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (st == IMPRIME) begin
                    cap_clr   = 1'b1;
                    cap_wr    = 1'b1;
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                case (st)
                    IMPRIME:         cap_wr    = 1'b1;
                    PRONTA, OCUPADA: state_nxt = ST_COMMIT;
                    default:         state_nxt = ST_IDLE;
                endcase
            end
            ST_COMMIT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign frame_ok = (state == ST_COMMIT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            pos_ovf <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= DIG_BLANK;
                disp[i]   <= DIG_BLANK;
            end
        end else begin
            state <= state_nxt;
            if (cap_wr && !pos_ok)
                pos_ovf <= 1'b1;
            // Frame start blanks every entry so a shorter frame never inherits stale digits
            for (int i = 0; i < 8; i++) begin
                if (cap_wr && pos_ok && pos[2:0] == 3'(i))
                    shadow[i] <= dig;
                else if (cap_clr)
                    shadow[i] <= DIG_BLANK;
            end
            if (state == ST_COMMIT) begin
                for (int i = 0; i < 8; i++)
                    disp[i] <= shadow[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == 16'(REFRESH_DIV - 1)) begin
            scan_cnt <= '0;
            scan_idx <= scan_idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 16'd1;
        end
    end

    assign err_mode = (st == ERRO);
    assign dec_code = err_mode ? {1'b0, scan_idx} : disp[scan_idx];

    seg7_decoder u_dec (
        .code (dec_code),
        .err  (err_mode),
        .seg  (dec_seg)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            an  <= 8'hFF;
            seg <= 8'hFF;
        end else begin
            an  <= ~(8'h01 << scan_idx);
            seg <= dec_seg;
        end
    end

endmodule

// File: tb/tb_calc_display.sv
// tb/tb_calc_display.sv - directed self-checking bench for calc_display
module tb_calc_display;

    logic       clock;
    logic       reset;
    logic [1:0] status;
    logic [3:0] pos;
    logic [3:0] dig;
    logic [7:0] an;
    logic [7:0] seg;
    logic       frame_ok;
    logic       pos_ovf;

    int checks   = 0;
    int failures = 0;
    int fok_cnt  = 0;
    int fok_base;

    localparam logic [1:0] S_ERRO    = 2'b00;
    localparam logic [1:0] S_PRONTA  = 2'b01;
    localparam logic [1:0] S_IMPRIME = 2'b11;

    calc_display #(.REFRESH_DIV(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .status   (status),
        .pos      (pos),
        .dig      (dig),
        .an       (an),
        .seg      (seg),
        .frame_ok (frame_ok),
        .pos_ovf  (pos_ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) if (frame_ok === 1'b1) fok_cnt++;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic imprime(input logic [3:0] p, input logic [3:0] d);
        @(negedge clock);
        status = S_IMPRIME;
        pos    = p;
        dig    = d;
    endtask

    task automatic finish_frame();
        @(negedge clock);
        status = S_PRONTA;
        repeat (4) @(negedge clock);
    endtask

    task automatic expect_pos(input int p, input logic [7:0] exp, input string tag);
        logic [7:0] want_an;
        bit found;
        want_an = ~(8'h01 << p);
        found   = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock);
            if (an === want_an) found = 1'b1;
        end
        if (found) check(tag, seg, exp);
        else       check({tag, "_timeout"}, an, want_an);
    endtask

    initial begin
        reset  = 1'b0;
        status = S_PRONTA;
        pos    = 4'd0;
        dig    = 4'hF;
        repeat (3) @(negedge clock);
        check("rst_an", an, 8'hFF);
        check("rst_seg", seg, 8'hFF);
        check("rst_frame_ok", frame_ok, 1'b0);
        check("rst_pos_ovf", pos_ovf, 1'b0);
        reset = 1'b1;

        // Idle scan: anode walks one position every 4 cycles, display blank
        fok_base = fok_cnt;
        for (int k = 1; k <= 64; k++) begin
            logic [7:0] exp_an;
            @(negedge clock);
            exp_an = ~(8'h01 << (((k - 1) / 4) % 8));
            check($sformatf("scan_an_%0d", k), an, exp_an);
            check($sformatf("scan_seg_%0d", k), seg, 8'hFF);
        end
        check("scan_no_frame", fok_cnt - fok_base, 0);

        // Frame 1: "-23"
        fok_base = fok_cnt;
        imprime(4'd0, 4'd3);
        imprime(4'd1, 4'd2);
        imprime(4'd2, 4'hA);
        finish_frame();
        check("f1_frame_ok", fok_cnt - fok_base, 1);
        expect_pos(0, 8'hB0, "f1_p0");
        expect_pos(1, 8'hA4, "f1_p1");
        expect_pos(2, 8'hBF, "f1_p2");
        for (int p = 3; p < 8; p++) expect_pos(p, 8'hFF, $sformatf("f1_p%0d", p));

        // Frame 2: single digit, earlier entries must be cleared
        fok_base = fok_cnt;
        imprime(4'd0, 4'd7);
        finish_frame();
        check("f2_frame_ok", fok_cnt - fok_base, 1);
        expect_pos(0, 8'hF8, "f2_p0");
        expect_pos(1, 8'hFF, "f2_p1");
        expect_pos(2, 8'hFF, "f2_p2");

        // Error aborts capture and shows "Erro"
        fok_base = fok_cnt;
        imprime(4'd0, 4'd5);
        @(negedge clock);
        status = S_ERRO;
        repeat (2) @(negedge clock);
        expect_pos(3, 8'h86, "err_p3");
        expect_pos(2, 8'hAF, "err_p2");
        expect_pos(1, 8'hAF, "err_p1");
        expect_pos(0, 8'hA3, "err_p0");
        expect_pos(7, 8'hFF, "err_p7");
        check("err_no_frame", fok_cnt - fok_base, 0);
        status = S_PRONTA;
        repeat (2) @(negedge clock);
        expect_pos(0, 8'hF8, "err_restore_p0");
        expect_pos(1, 8'hFF, "err_restore_p1");

        // Out-of-range position is dropped but flagged
        imprime(4'd0, 4'd7);
        imprime(4'd9, 4'd1);
        finish_frame();
        check("ovf_set", pos_ovf, 1'b1);
        expect_pos(0, 8'hF8, "ovf_p0");
        expect_pos(1, 8'hFF, "ovf_p1");
        imprime(4'd2, 4'd4);
        finish_frame();
        check("ovf_sticky", pos_ovf, 1'b1);
        expect_pos(2, 8'h99, "ovf2_p2");
        expect_pos(0, 8'hFF, "ovf2_p0");

        // Reset mid-capture
        fok_base = fok_cnt;
        imprime(4'd1, 4'd4);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("arst_an", an, 8'hFF);
        check("arst_seg", seg, 8'hFF);
        check("arst_pos_ovf", pos_ovf, 1'b0);
        @(negedge clock);
        status = S_PRONTA;
        reset  = 1'b1;
        repeat (3) @(negedge clock);
        check("arst_no_frame", fok_cnt - fok_base, 0);
        check("arst_pos_ovf_after", pos_ovf, 1'b0);
        expect_pos(0, 8'hFF, "arst_p0");
        expect_pos(1, 8'hFF, "arst_p1");
        expect_pos(2, 8'hFF, "arst_p2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
